// File: rtl/dtw_axis_sink_fifo.sv
// AXI4-Stream sink FIFO feeding the DTW sample loader.
// Stores {TLAST, strobe-masked TDATA}, tracks whole packets held and flags partial mid-packet beats.
`timescale 1ns/1ps
module dtw_axis_sink_fifo #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH           = 16,
    parameter int ALMOST_FULL_THRESH   = 12,
    parameter int FWFT                 = 0,
    localparam int PTR_W               = $clog2(FIFO_DEPTH)
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic                              S_AXIS_TVALID,
    input  logic                              dtw_fifo_flush,
    input  logic                              dtw_fifo_rden,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   dtw_fifo_dout,
    output logic                              dtw_fifo_dout_last,
    output logic                              dtw_fifo_dout_valid,
    output logic                              dtw_fifo_empty,
    output logic                              dtw_fifo_almost_full,
    output logic [PTR_W:0]                    dtw_fifo_count,
    output logic [PTR_W:0]                    dtw_pkt_count,
    output logic                              dtw_strb_err
);

    localparam int W  = C_S_AXIS_TDATA_WIDTH;
    localparam int NB = W / 8;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] AF_CNT   = (PTR_W + 1)'(ALMOST_FULL_THRESH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [W:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [W-1:0]     wdata;
    logic [W:0]       head;
    logic             full;
    logic             wr;
    logic             rd;
    logic             pkt_inc;
    logic             pkt_dec;

    assign full                 = (dtw_fifo_count == FULL_CNT);
    assign dtw_fifo_empty       = (dtw_fifo_count == '0);
    assign dtw_fifo_almost_full = (dtw_fifo_count >= AF_CNT);
    assign S_AXIS_TREADY        = !full && !dtw_fifo_flush && !S_AXIS_ARESET;

    assign wr      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign rd      = dtw_fifo_rden && !dtw_fifo_empty;
    assign head    = mem[rd_ptr];
    assign pkt_inc = wr && S_AXIS_TLAST;
    assign pkt_dec = rd && head[W];

    always_comb begin
        wdata = S_AXIS_TDATA;
        for (int unsigned i = 0; i < NB; i++) begin
            if (!S_AXIS_TSTRB[i]) wdata[8*i +: 8] = 8'h00;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (wr) mem[wr_ptr] <= {S_AXIS_TLAST, wdata};
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            dtw_fifo_count <= '0;
            dtw_pkt_count  <= '0;
            dtw_strb_err   <= 1'b0;
        end else if (dtw_fifo_flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            dtw_fifo_count <= '0;
            dtw_pkt_count  <= '0;
            dtw_strb_err   <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd) rd_ptr <= rd_ptr + PTR_ONE;
            if (wr && !rd)      dtw_fifo_count <= dtw_fifo_count + CNT_ONE;
            else if (!wr && rd) dtw_fifo_count <= dtw_fifo_count - CNT_ONE;
            if (pkt_inc && !pkt_dec)      dtw_pkt_count <= dtw_pkt_count + CNT_ONE;
            else if (!pkt_inc && pkt_dec) dtw_pkt_count <= dtw_pkt_count - CNT_ONE;
            // A short strobe is only legal on the closing beat of a packet.
            if (wr && !S_AXIS_TLAST && (S_AXIS_TSTRB != '1)) dtw_strb_err <= 1'b1;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head is gated while empty so stale memory never shows and reset yields zero outputs.
        assign dtw_fifo_dout       = dtw_fifo_empty ? '0 : head[W-1:0];
        assign dtw_fifo_dout_last  = !dtw_fifo_empty && head[W];
        assign dtw_fifo_dout_valid = !dtw_fifo_empty;
    end else begin : g_std
        always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
            if (S_AXIS_ARESET) begin
                dtw_fifo_dout       <= '0;
                dtw_fifo_dout_last  <= 1'b0;
                dtw_fifo_dout_valid <= 1'b0;
            end else if (dtw_fifo_flush) begin
                dtw_fifo_dout_valid <= 1'b0;
            end else begin
                dtw_fifo_dout_valid <= rd;
                if (rd) begin
                    dtw_fifo_dout      <= head[W-1:0];
                    dtw_fifo_dout_last <= head[W];
                end
            end
        end
    end

endmodule

// File: tb/tb_dtw_axis_sink_fifo.sv
// Bench for dtw_axis_sink_fifo: queue-based model for the standard-mode instance plus
// directed literal checks, and directed checks on a small first-word-fall-through instance.
`timescale 1ns/1ps
module tb_dtw_axis_sink_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Standard-mode instance (defaults: 32-bit, depth 16, threshold 12)
    logic        tready, tlast = 1'b0, tvalid = 1'b0, flush = 1'b0, rden = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = 4'hF;
    logic [31:0] dout;
    logic        dout_last, dout_valid, empty, af, serr;
    logic [4:0]  count, pkt;

    // First-word-fall-through instance (depth 4, threshold 3)
    logic        b_tready, b_tlast = 1'b0, b_tvalid = 1'b0, b_flush = 1'b0, b_rden = 1'b0;
    logic [31:0] b_tdata = '0;
    logic [3:0]  b_tstrb = 4'hF;
    logic [31:0] b_dout;
    logic        b_last, b_valid, b_empty, b_af, b_serr;
    logic [2:0]  b_count, b_pkt;

    dtw_axis_sink_fifo #(
        .C_S_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(16), .ALMOST_FULL_THRESH(12), .FWFT(0)
    ) dut0 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TREADY(tready),
        .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
        .S_AXIS_TVALID(tvalid), .dtw_fifo_flush(flush), .dtw_fifo_rden(rden),
        .dtw_fifo_dout(dout), .dtw_fifo_dout_last(dout_last), .dtw_fifo_dout_valid(dout_valid),
        .dtw_fifo_empty(empty), .dtw_fifo_almost_full(af), .dtw_fifo_count(count),
        .dtw_pkt_count(pkt), .dtw_strb_err(serr)
    );

    dtw_axis_sink_fifo #(
        .C_S_AXIS_TDATA_WIDTH(32), .FIFO_DEPTH(4), .ALMOST_FULL_THRESH(3), .FWFT(1)
    ) dut1 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TREADY(b_tready),
        .S_AXIS_TDATA(b_tdata), .S_AXIS_TSTRB(b_tstrb), .S_AXIS_TLAST(b_tlast),
        .S_AXIS_TVALID(b_tvalid), .dtw_fifo_flush(b_flush), .dtw_fifo_rden(b_rden),
        .dtw_fifo_dout(b_dout), .dtw_fifo_dout_last(b_last), .dtw_fifo_dout_valid(b_valid),
        .dtw_fifo_empty(b_empty), .dtw_fifo_almost_full(b_af), .dtw_fifo_count(b_count),
        .dtw_pkt_count(b_pkt), .dtw_strb_err(b_serr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model of the standard-mode instance ----------------
    logic [32:0] q[$];
    logic [31:0] m_dout  = '0;
    logic        m_last  = 1'b0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;

    function automatic logic [31:0] apply_strb(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) if (s[i]) r = r | (d & (32'hFF << (8 * i)));
        return r;
    endfunction

    function automatic int packets_held();
        int n;
        n = 0;
        foreach (q[i]) if (q[i][32]) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_dout = '0; m_last = 1'b0; m_valid = 1'b0; m_err = 1'b0;
        end else if (flush) begin
            q.delete();
            m_valid = 1'b0; m_err = 1'b0;
        end else begin
            logic do_rd, do_wr;
            logic [32:0] e;
            do_rd = rden && (q.size() > 0);
            do_wr = tvalid && (q.size() < 16);
            m_valid = do_rd;
            if (do_rd) begin
                e = q.pop_front();
                m_last = e[32];
                m_dout = e[31:0];
            end
            if (do_wr) begin
                q.push_back({tlast, apply_strb(tdata, tstrb)});
                if (tstrb != 4'hF && !tlast) m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("tready", tready, !rst && !flush && (q.size() < 16));
        check("count", count, q.size());
        check("count_le_depth", count <= 5'd16, 1'b1);
        check("pkt_count", pkt, packets_held());
        check("empty", empty, q.size() == 0);
        check("almost_full", af, q.size() >= 12);
        check("strb_err", serr, m_err);
        check("dout_valid", dout_valid, m_valid);
        check("dout", dout, m_dout);
        check("dout_last", dout_last, m_last);
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic l);
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        cyc();
        tvalid = 1'b0; tlast = 1'b0; tstrb = 4'hF;
    endtask

    task automatic read1();
        rden = 1'b1;
        cyc();
        rden = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        // Reset state
        cyc();
        check("rst_count", count, 0);
        check("rst_tready", tready, 0);
        check("rst_dout_valid", dout_valid, 0);
        cyc();
        rst = 1'b0;

        // Fill to full with 0x1..0x10
        for (int i = 0; i < 16; i++) begin
            tdata = 32'(i + 1); tvalid = 1'b1;
            cyc();
            if (i == 10) check("af_at_11", af, 0);
            if (i == 11) check("af_at_12", af, 1);
        end
        tvalid = 1'b0;
        check("full_count", count, 16);
        check("full_tready", tready, 0);
        check("full_af", af, 1);

        // Drain in order
        for (int i = 0; i < 16; i++) begin
            rden = 1'b1;
            cyc();
            check("drain_valid", dout_valid, 1);
            check("drain_dout", dout, 32'(i + 1));
        end
        rden = 1'b0;
        cyc();
        check("drain_valid_end", dout_valid, 0);
        check("drain_empty", empty, 1);

        // Write and read together while full
        for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 4'hF, 1'b0);
        tdata = 32'h999; tvalid = 1'b1; rden = 1'b1;
        cyc();
        rden = 1'b0;
        check("full_pop_count", count, 15);
        check("full_pop_tready", tready, 1);
        check("full_pop_dout", dout, 32'h100);
        cyc();
        tvalid = 1'b0;
        check("refill_count", count, 16);

        // Random traffic, then drain
        for (int i = 0; i < 100; i++) begin
            tvalid = 1'($urandom_range(0, 1));
            rden   = 1'($urandom_range(0, 1));
            tlast  = 1'($urandom_range(0, 1));
            tdata  = $urandom;
            cyc();
        end
        tvalid = 1'b0; tlast = 1'b0;
        rden = 1'b1;
        repeat (20) cyc();
        rden = 1'b0;
        cyc();
        check("rand_drained", empty, 1);

        // Packets of 3 and 5 beats, short strobe on the last beat
        send(32'h1, 4'hF, 1'b0);
        send(32'h2, 4'hF, 1'b0);
        send(32'hAABBCCDD, 4'b0011, 1'b1);
        check("pkt_after_first", pkt, 1);
        for (int i = 0; i < 4; i++) send(32'h10 + 32'(i), 4'hF, 1'b0);
        send(32'hAABBCCDD, 4'b0011, 1'b1);
        check("pkt_after_second", pkt, 2);
        check("strb_err_clean", serr, 0);
        repeat (3) read1();
        check("last_word_dout", dout, 32'h0000CCDD);
        check("last_word_flag", dout_last, 1);
        check("pkt_after_read1", pkt, 1);
        repeat (5) read1();
        check("last_word2_dout", dout, 32'h0000CCDD);
        check("pkt_after_read2", pkt, 0);

        // Partial strobe mid-packet is sticky
        send(32'h11223344, 4'b0111, 1'b0);
        check("strb_err_set", serr, 1);
        send(32'h99, 4'hF, 1'b1);
        check("strb_err_sticky", serr, 1);

        // Flush with 7 words, 2 packets, error set and rden high
        for (int i = 0; i < 4; i++) send(32'h61 + 32'(i), 4'hF, 1'b0);
        send(32'h65, 4'hF, 1'b1);
        check("preflush_count", count, 7);
        check("preflush_pkt", pkt, 2);
        check("preflush_err", serr, 1);
        flush = 1'b1; rden = 1'b1;
        #1;
        check("flush_tready", tready, 0);
        cyc();
        flush = 1'b0; rden = 1'b0;
        check("flush_count", count, 0);
        check("flush_pkt", pkt, 0);
        check("flush_err", serr, 0);
        check("flush_no_valid", dout_valid, 0);
        check("flush_dout_held", dout, 32'h0000CCDD);
        send(32'h55, 4'hF, 1'b0);
        check("postflush_count", count, 1);
        read1();
        check("postflush_dout", dout, 32'h55);

        // Asynchronous reset mid-packet
        send(32'h71, 4'hF, 1'b0);
        send(32'h72, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_tready", tready, 0);
        check("async_rst_empty", empty, 1);
        check("async_rst_dout", dout, 0);
        cyc();
        rst = 1'b0;
        send(32'h77, 4'hF, 1'b1);
        read1();
        check("post_rst_dout", dout, 32'h77);
        check("post_rst_last", dout_last, 1);

        // First-word-fall-through instance
        check("fwft_empty0", b_empty, 1);
        check("fwft_valid0", b_valid, 0);
        b_tdata = 32'hA; b_tvalid = 1'b1;
        cyc();
        check("fwft_first_dout", b_dout, 32'hA);
        check("fwft_first_valid", b_valid, 1);
        b_tdata = 32'hB;
        cyc();
        b_tvalid = 1'b0;
        check("fwft_dout_a", b_dout, 32'hA);
        check("fwft_count2", b_count, 2);
        check("fwft_af", b_af, 0);
        check("fwft_last", b_last, 0);
        check("fwft_tready", b_tready, 1);
        check("fwft_pkt", b_pkt, 0);
        check("fwft_serr", b_serr, 0);
        b_rden = 1'b1;
        cyc();
        b_rden = 1'b0;
        check("fwft_dout_b", b_dout, 32'hB);
        check("fwft_valid_b", b_valid, 1);
        b_rden = 1'b1;
        cyc();
        b_rden = 1'b0;
        check("fwft_valid_end", b_valid, 0);
        check("fwft_empty_end", b_empty, 1);

        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dtw_axis_sink_fifo.md
Name: dtw_axis_sink_fifo

Overview:
Parametrised AXI4-Stream sink FIFO feeding the DTW core with query/reference samples. Successor to the fixed 8-deep sink: generic width and depth, a correct full count, and stored TLAST with packet accounting. Also adds TSTRB byte masking, a selectable standard or first-word-fall-through read mode, an almost-full flag and a synchronous flush. Sits between the DMA AXIS master and the DTW sample loader.

Parameters:
C_S_AXIS_TDATA_WIDTH, 32, data width in bits; a multiple of 8.
FIFO_DEPTH, 16, number of entries; a power of 2, at least 2.
ALMOST_FULL_THRESH, 12, dtw_fifo_almost_full asserts when count >= this value; range 1..FIFO_DEPTH.
FWFT, 0, read mode: 0 = standard (registered, 1-cycle latency), 1 = first-word-fall-through.
PTR_W, derived as clog2(FIFO_DEPTH); not user-set.

Ports:
S_AXIS_ACLK  in  1  single clock for the block
S_AXIS_ARESET  in  1  asynchronous, active-high reset
S_AXIS_TREADY  out  1  sink ready
S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH  stream data
S_AXIS_TSTRB  in  C_S_AXIS_TDATA_WIDTH/8  byte qualifiers
S_AXIS_TLAST  in  1  last beat of packet
S_AXIS_TVALID  in  1  stream valid
dtw_fifo_flush  in  1  synchronous flush
dtw_fifo_rden  in  1  read/pop request
dtw_fifo_dout  out  C_S_AXIS_TDATA_WIDTH  read data
dtw_fifo_dout_last  out  1  TLAST stored with dtw_fifo_dout
dtw_fifo_dout_valid  out  1  dout qualifier
dtw_fifo_empty  out  1  count == 0
dtw_fifo_almost_full  out  1  count >= ALMOST_FULL_THRESH
dtw_fifo_count  out  PTR_W+1  occupancy, 0..FIFO_DEPTH
dtw_pkt_count  out  PTR_W+1  complete packets (TLAST words) held
dtw_strb_err  out  1  sticky partial-strobe error

Behaviour:
- Reset: asynchronous, active-high. Clears pointers, count, pkt_count, dout, dout_last, dout_valid and strb_err to 0. TREADY is 0 while reset is asserted. Memory contents are don't-care.
- Ready and write:
  - TREADY = !full && !flush && !reset, where full = (count == FIFO_DEPTH) taken from the registered count. There is no IDLE/WRITE state gating.
  - wr = TVALID && TREADY.
  - On wr, the entry stores {TLAST, masked TDATA}. Each byte whose TSTRB bit is 0 is written as 8'h00.
- Read:
  - rd = dtw_fifo_rden && !empty. rden while empty is ignored: no pointer change, no error.
  - FWFT=0: on rd, dout and dout_last load the head entry at the next edge and dout_valid pulses high for exactly 1 cycle. When there is no rd, dout holds its value and dout_valid is 0.
  - FWFT=1: dout and dout_last present the head entry combinationally, with dout_valid = !empty. rd pops the entry, and the next entry appears in the same cycle the pointer updates.
- Pointers: PTR_W bits, natural binary wrap from FIFO_DEPTH-1 to 0.
- Count:
  - +1 on wr only, -1 on rd only, unchanged when wr and rd occur together.
  - Width PTR_W+1, so FIFO_DEPTH is representable.
- Simultaneous wr and rd:
  - When empty: only wr can occur; the word becomes readable on the next cycle.
  - When full: only rd can occur, because TREADY is low. TREADY rises the cycle after the pop.
- Packet count:
  - +1 on a wr with TLAST, -1 on a rd of an entry with stored last=1, unchanged when both occur together.
  - Never exceeds count.
- Strobe error: strb_err is set on a wr where TSTRB is not all ones and TLAST = 0 (a partial beat mid-packet). It stays set until flush or reset. A partial strobe on the TLAST beat is legal.
- Flush:
  - While dtw_fifo_flush is high, TREADY = 0.
  - At the edge, pointers, count, pkt_count, dout_valid and strb_err go to 0. dout keeps its value.
  - Flush takes priority over a concurrent rd; no dout_valid pulse is produced.
- Reset mid-packet: all buffered words are discarded and no partial state is retained.
- Flag timing: almost_full and empty are derived combinationally from the registered count.

Test Plan:
- Defaults (32-bit, depth 16, FWFT=0): stream 16 beats 0x1..0x10 with rden=0 -> TREADY drops after the 16th beat, count = 16, almost_full asserted from count 12. Then rden held for 16 cycles -> dout = 0x1..0x10 in order with one dout_valid pulse each, ending with empty = 1.
- Simultaneous ops: when full, assert TVALID and rden together -> one pop occurs, TREADY rises the next cycle, and count stays between 15 and 16. Run 100 cycles of random TVALID/rden -> output order matches a scoreboard and count never exceeds 16.
- Packets and strobes: send packets of 3 and 5 beats, with the last beat TSTRB = 4'b0011 and data 0xAABBCCDD -> pkt_count goes 1 then 2, the stored last word is 0x0000CCDD with dout_last = 1, and pkt_count decrements on each last-word read. A mid-packet beat with TSTRB = 4'b0111 -> strb_err goes to 1 and stays set.
- FWFT=1, depth 4: write 0xA, 0xB -> dout = 0xA with dout_valid = 1 before any rden. One rden -> dout = 0xB the next cycle. A second rden -> dout_valid = 0 and empty = 1.
- Flush while 7 words are buffered, pkt_count = 2 and strb_err = 1, with rden high -> the next cycle shows count = 0, pkt_count = 0, strb_err = 0 and no dout_valid. A write on the following cycle is accepted normally.
- Assert reset asynchronously mid-packet, between clock edges -> outputs clear immediately. After release, the first new beat reads back as the first word.
